regc_dispatch: RTL and testbench

//  Return-path router for register C in the MFCC datapath. It accepts 16-bit words

---
 rtl/mfcc_pkg.sv | 21 ++
 rtl/mfcc_frame_cnt.sv | 54 +++++
 rtl/regc_dispatch.sv | 127 ++++++++++++
 tb/tb_regc_dispatch.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mfcc_pkg.sv
// Shared definitions for the MFCC datapath.
// Destination codes are shared with the muxregc select encoding, so any
// change here moves both the register C return path and the forward mux.
package mfcc_pkg;

   localparam int DATA_W_DEF = 16;

   localparam logic [1:0] DST_DROP  = 2'b00;
   localparam logic [1:0] DST_LOG   = 2'b01;
   localparam logic [1:0] DST_DCT   = 2'b10;
   localparam logic [1:0] DST_DELTA = 2'b11;

   // Holding-stage occupancy, kept as plain constants for legacy tools
   localparam logic [0:0] ST_EMPTY = 1'b0;
   localparam logic [0:0] ST_FULL  = 1'b1;

   function automatic logic dst_is_drop(input logic [1:0] dst);
      return dst == DST_DROP;
   endfunction

endpackage

// File: rtl/mfcc_frame_cnt.sv
// Modulo-FRAME_LEN event counter with a registered wrap pulse.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   clr       - synchronous clear (count and pulse to 0), lower priority than rst
//   inc       - count one event this cycle
//   cnt       - events counted in the current frame (0..FRAME_LEN-1)
//   wrap      - 1-cycle pulse, the cycle after the event that completed a frame
module mfcc_frame_cnt #(
   parameter int FRAME_LEN = 26,
   parameter int CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt,
   output logic             wrap
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             wrap_q, wrap_d;

   always_comb begin
      cnt_d  = cnt_q;
      wrap_d = 1'b0;
      if (clr) begin
         cnt_d  = '0;
         wrap_d = 1'b0;
      end else if (inc) begin
         if (cnt_q == LAST) begin
            cnt_d  = '0;
            wrap_d = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         wrap_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         wrap_q <= wrap_d;
      end
   end

   assign cnt  = cnt_q;
   assign wrap = wrap_q;

endmodule

// File: rtl/regc_dispatch.sv
// Return-path router for register C. Words leaving register C are held in a
// one-entry registered stage and offered to exactly one consumer (log, DCT
// add/sub or delta). Destination 00 words are discarded and counted.
// Ports:
//   clk, rst, flush             - clock, sync reset, sync clear of stage and counters
//   regc_in/regc_dst/regc_valid - upstream word, destination code, valid
//   regc_ready                  - upstream handshake
//   disp_data                   - held word, broadcast to all consumers
//   log_/dct_/delta_valid/ready - per-consumer handshakes
//   word_cnt                    - words delivered in the current frame
//   drop_cnt                    - dst 00 words accepted, saturating
//   frame_done                  - registered pulse after the last word of a frame
module regc_dispatch
   import mfcc_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int FRAME_LEN = 26,
   parameter int CNT_W     = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic [DATA_W-1:0] regc_in,
   input  logic [1:0]        regc_dst,
   input  logic              regc_valid,
   output logic              regc_ready,
   output logic [DATA_W-1:0] disp_data,
   output logic              log_valid,
   input  logic              log_ready,
   output logic              dct_valid,
   input  logic              dct_ready,
   output logic              delta_valid,
   input  logic              delta_ready,
   output logic [CNT_W-1:0]  word_cnt,
   output logic [CNT_W-1:0]  drop_cnt,
   output logic              frame_done
);

   logic [0:0]        state_q, state_d;
   logic [1:0]        dst_q, dst_d;
   logic [DATA_W-1:0] hold_q, hold_d;
   logic [CNT_W-1:0]  drop_q, drop_d;

   logic sel_ready;
   logic xfer;
   logic accept;
   logic load;

   always_comb begin
      sel_ready = 1'b0;
      case (dst_q)
         DST_LOG:   sel_ready = log_ready;
         DST_DCT:   sel_ready = dct_ready;
         DST_DELTA: sel_ready = delta_ready;
         default:   sel_ready = 1'b0;
      endcase
   end

   assign xfer       = (state_q == ST_FULL) & sel_ready;
   // Ready while empty or while the held word leaves this cycle; flush blocks intake
   assign regc_ready = ~flush & ((state_q == ST_EMPTY) | sel_ready);
   // accept is 0 whenever regc_valid is 0, so a junk regc_dst cannot leak through
   assign accept     = regc_valid & regc_ready;
   assign load       = accept & ~dst_is_drop(regc_dst);

   always_comb begin
      state_d = state_q;
      dst_d   = dst_q;
      hold_d  = hold_q;
      drop_d  = drop_q;
      if (flush) begin
         state_d = ST_EMPTY;
         dst_d   = DST_DROP;
         hold_d  = '0;
         drop_d  = '0;
      end else begin
         if (load) begin
            state_d = ST_FULL;
            dst_d   = regc_dst;
            hold_d  = regc_in;
         end else if (xfer) begin
            state_d = ST_EMPTY;
         end
         if (accept && dst_is_drop(regc_dst) && (drop_q != '1)) begin
            drop_d = drop_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_EMPTY;
         dst_q   <= DST_DROP;
         hold_q  <= '0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         dst_q   <= dst_d;
         hold_q  <= hold_d;
         drop_q  <= drop_d;
      end
   end

   // A transfer completing during flush still reaches the consumer but is not counted
   mfcc_frame_cnt #(
      .FRAME_LEN (FRAME_LEN),
      .CNT_W     (CNT_W)
   ) u_frame_cnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (flush),
      .inc  (xfer),
      .cnt  (word_cnt),
      .wrap (frame_done)
   );

   assign disp_data   = hold_q;
   assign log_valid   = (state_q == ST_FULL) & (dst_q == DST_LOG);
   assign dct_valid   = (state_q == ST_FULL) & (dst_q == DST_DCT);
   assign delta_valid = (state_q == ST_FULL) & (dst_q == DST_DELTA);
   assign drop_cnt    = drop_q;

   // Upstream must hold regc_valid until the word is taken
   a_valid_hold: assert property (@(posedge clk) disable iff (rst || flush)
      (regc_valid && !regc_ready) |=> regc_valid);

endmodule

// File: tb/tb_regc_dispatch.sv
module tb_regc_dispatch;

   localparam int FL = 26;

   logic        clk = 1'b0;
   logic        rst, flush;
   logic [15:0] regc_in;
   logic [1:0]  regc_dst;
   logic        regc_valid, regc_ready;
   logic [15:0] disp_data;
   logic        log_valid, log_ready, dct_valid, dct_ready, delta_valid, delta_ready;
   logic [7:0]  word_cnt, drop_cnt;
   logic        frame_done;

   always #5 clk = ~clk;

   regc_dispatch #(.DATA_W(16), .FRAME_LEN(FL), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .regc_in(regc_in), .regc_dst(regc_dst), .regc_valid(regc_valid), .regc_ready(regc_ready),
      .disp_data(disp_data),
      .log_valid(log_valid), .log_ready(log_ready),
      .dct_valid(dct_valid), .dct_ready(dct_ready),
      .delta_valid(delta_valid), .delta_ready(delta_ready),
      .word_cnt(word_cnt), .drop_cnt(drop_cnt), .frame_done(frame_done)
   );

   // Reference model: queue of words accepted but not yet delivered, plus counts
   typedef struct packed { logic [15:0] data; logic [1:0] dst; } word_t;
   word_t mq[$];
   int    m_wcnt = 0;
   int    m_drop = 0;
   bit    m_fd   = 0;

   int checks = 0;
   int errors = 0;
   bit chk_en = 0;
   bit last_acc, last_xfer;
   int fd_seen = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit rdy_of(input logic [1:0] d);
      case (d)
         2'b01:   return log_ready;
         2'b10:   return dct_ready;
         2'b11:   return delta_ready;
         default: return 1'b0;
      endcase
   endfunction

   // One clock: check outputs at negedge, advance the model, return #1 after posedge
   task automatic step();
      bit exp_ready, xf;
      @(negedge clk);
      exp_ready = !flush && (mq.size() == 0 || rdy_of(mq[0].dst));
      if (chk_en) begin
         chk("log_valid",   log_valid,   mq.size() > 0 && mq[0].dst == 2'b01);
         chk("dct_valid",   dct_valid,   mq.size() > 0 && mq[0].dst == 2'b10);
         chk("delta_valid", delta_valid, mq.size() > 0 && mq[0].dst == 2'b11);
         if (mq.size() > 0) chk("disp_data", disp_data, mq[0].data);
         chk("regc_ready", regc_ready, exp_ready);
         chk("word_cnt",   word_cnt,   m_wcnt);
         chk("drop_cnt",   drop_cnt,   m_drop);
         chk("frame_done", frame_done, m_fd);
      end
      if (frame_done) fd_seen++;
      xf        = mq.size() > 0 && rdy_of(mq[0].dst);
      last_acc  = regc_valid && exp_ready;
      last_xfer = xf;
      if (rst) begin
         mq.delete(); m_wcnt = 0; m_drop = 0; m_fd = 0;
      end else if (flush) begin
         mq.delete(); m_wcnt = 0; m_drop = 0; m_fd = 0;
      end else begin
         m_fd = xf && (m_wcnt == FL - 1);
         if (xf) begin
            void'(mq.pop_front());
            m_wcnt = (m_wcnt + 1) % FL;
         end
         if (last_acc) begin
            if (regc_dst == 2'b00) begin
               if (m_drop < 255) m_drop++;
            end else begin
               mq.push_back('{data: regc_in, dst: regc_dst});
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [15:0] d, input logic [1:0] dst);
      int guard = 0;
      regc_valid = 1'b1; regc_in = d; regc_dst = dst;
      do begin
         step();
         guard++;
      end while (!last_acc && guard < 50);
      if (!last_acc) chk("accept_timeout", 0, 1);
      regc_valid = 1'b0;
      regc_dst   = 2'($urandom);
   endtask

   initial begin
      int fd0;
      rst = 1'b1; flush = 1'b0; regc_valid = 1'b0; regc_in = '0; regc_dst = '0;
      log_ready = 1'b0; dct_ready = 1'b0; delta_ready = 1'b0;
      @(posedge clk); #1;

      // 1. reset for 2 cycles, outputs checked from the second cycle on
      step();
      chk_en = 1;
      step();
      rst = 1'b0;
      step();
      chk("rst_ready", regc_ready, 1);

      // 2. single word to log
      log_ready = 1'b1;
      send(16'h1234, 2'b01);
      step();
      step();
      chk("t2_wcnt", word_cnt, 1);

      // 3. delta stalls for 3 cycles, then transfer and reload in the same cycle
      delta_ready = 1'b0;
      send(16'hBEEF, 2'b11);
      regc_valid = 1'b1; regc_in = 16'h0001; regc_dst = 2'b10;
      repeat (3) step();
      chk("t3_stalled", regc_ready, 0);
      delta_ready = 1'b1;
      step();
      chk("t3_xfer_and_load", {last_xfer, last_acc}, 2'b11);
      regc_valid = 1'b0;
      dct_ready  = 1'b1;
      step();
      step();

      // 4. full frame, streamed back to back
      flush = 1'b1;
      step();
      flush = 1'b0;
      fd0 = fd_seen;
      for (int i = 0; i < FL; i++) begin
         regc_valid = 1'b1; regc_in = 16'(16'h0100 + i); regc_dst = (i % 2 == 0) ? 2'b01 : 2'b10;
         step();
         chk("t4_no_bubble", last_acc, 1);
      end
      regc_valid = 1'b0;
      repeat (3) step();
      chk("t4_fd_pulses", fd_seen - fd0, 1);
      chk("t4_wrap", word_cnt, 0);

      // 5. drops interleaved with real words
      for (int i = 0; i < 6; i++) send(16'(16'hD000 + i), (i % 2 == 0) ? 2'b01 : 2'b00);
      repeat (2) step();
      chk("t5_drops", drop_cnt, 3);
      chk("t5_wcnt", word_cnt, 3);

      // 6. flush while FULL and stalled, with a word waiting upstream
      log_ready = 1'b0;
      send(16'hCAFE, 2'b01);
      regc_valid = 1'b1; regc_in = 16'h5555; regc_dst = 2'b10;
      flush = 1'b1;
      step();
      chk("t6_ready_in_flush", last_acc, 0);
      flush = 1'b0;
      step();
      chk("t6_accept_after", last_acc, 1);
      regc_valid = 1'b0;
      repeat (3) step();

      // drop counter saturation
      flush = 1'b1;
      step();
      flush = 1'b0;
      for (int i = 0; i < 260; i++) send(16'($urandom), 2'b00);
      step();
      chk("sat_drop", drop_cnt, 255);

      // randomized traffic with occasional flush and reset
      for (int c = 0; c < 1500; c++) begin
         log_ready   = 1'($urandom);
         dct_ready   = 1'($urandom);
         delta_ready = ($urandom % 4) != 0;
         if (!regc_valid) begin
            if ($urandom % 3 != 0) begin
               regc_valid = 1'b1; regc_in = 16'($urandom); regc_dst = 2'($urandom);
            end else begin
               regc_dst = 2'($urandom);
            end
         end
         flush = ($urandom % 60) == 0;
         rst   = ($urandom % 300) == 0;
         step();
         if (last_acc) regc_valid = 1'b0;
      end
      flush = 1'b0; rst = 1'b0; regc_valid = 1'b0;
      log_ready = 1'b1; dct_ready = 1'b1; delta_ready = 1'b1;
      repeat (3) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
